// File: rtl/logic_gates_seq.sv
// -----------------------------------------------------------------------------
// logic_gates_seq
//   Registered, parametrised bitwise-gate stage. An operand beat (A, B, opcode)
//   is accepted through a valid/ready handshake. One of eight bitwise
//   operations is applied, and the result is held in a one-entry output
//   register until the consumer takes it. The last result can be fed back as
//   operand A (chaining). Zero and parity flags are registered alongside the
//   result, and a free-running counter tallies accepted beats.
//
// Parameters
//   WIDTH   operand/result width in bits (1..32)
//   CNT_W   width of the accepted-beat counter
//
// Ports
//   iClk     in   1      clock, rising edge
//   iRst     in   1      synchronous reset, active-high
//   iValid   in   1      operand beat valid
//   oReady   out  1      beat can be accepted this cycle
//   iA       in   WIDTH  operand A
//   iB       in   WIDTH  operand B
//   iOp      in   3      operation select
//   iChain   in   1      use last result in place of iA
//   oValid   out  1      output register holds an unconsumed result
//   iReady   in   1      consumer takes the result this cycle
//   oResult  out  WIDTH  registered result
//   oZero    out  1      registered flag: oResult == 0
//   oParity  out  1      registered flag: XOR-reduction of oResult
//   oCount   out  CNT_W  accepted beats since reset, modulo 2^CNT_W
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module logic_gates_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [2:0]       iOp,
  input  logic             iChain,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oZero,
  output logic             oParity,
  output logic [CNT_W-1:0] oCount
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASSB = 3'd7
  } op_t;

  // The output register is either holding an unconsumed result or not.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_parity;
  logic [CNT_W-1:0] r_count;

  logic             w_ready;
  logic             w_accept;
  logic             w_consume;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_op_res;

  // Ready only looks at the output register, never at iValid, so the
  // upstream source cannot form a combinational loop through this stage.
  // Taking a new beat while the consumer drains the old one gives one beat
  // per cycle.
  assign w_ready   = (r_state == EMPTY) || iReady;
  assign w_accept  = iValid && w_ready;
  assign w_consume = (r_state == FULL) && iReady;

  // Chaining reads the retained result. That value survives consumption and
  // is zero after reset.
  assign w_a = iChain ? r_result : iA;

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_op_res = '0;
    unique case (op_t'(iOp))
      OP_AND:   w_op_res = w_a & iB;
      OP_OR:    w_op_res = w_a | iB;
      OP_NOTA:  w_op_res = ~w_a;
      OP_NAND:  w_op_res = ~(w_a & iB);
      OP_NOR:   w_op_res = ~(w_a | iB);
      OP_XOR:   w_op_res = w_a ^ iB;
      OP_XNOR:  w_op_res = ~(w_a ^ iB);
      OP_PASSB: w_op_res = iB;
      default:  w_op_res = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every register
  // here samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      // Reset outranks a same-cycle accept or consume.
      r_state  <= EMPTY;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_parity <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        // Covers both EMPTY->FULL and a FULL->FULL drain-and-refill.
        r_state  <= FULL;
        r_result <= w_op_res;
        r_zero   <= (w_op_res == '0);
        r_parity <= ^w_op_res;
        r_count  <= r_count + CNT_W'(1);
      end else if (w_consume) begin
        // Data and flags are kept so a later chain beat can still use them.
        r_state <= EMPTY;
      end
    end
  end

  assign oReady  = w_ready;
  assign oValid  = (r_state == FULL);
  assign oResult = r_result;
  assign oZero   = r_zero;
  assign oParity = r_parity;
  assign oCount  = r_count;

endmodule
